flow_input_arbiter: RTL and testbench
=====================================

Name: flow_input_arbiter

Overview:
- Upstream stage of the multi-flow 8-tap HEVC filter core.
- Accepts FLUX independent untagged pixel streams and buffers each one in its own FIFO.
- Merges the streams round-robin into the single tagged write-stream consumed by the filter's in_port (tag in MSBs, same format as the filter's in_pel interface).
- Gates each flow by a per-flow block length, loaded from ext_size, so that exactly ext_size*ext_size pixels per block reach the filter.

Parameters:
- FLUX, 2, number of concurrent flows.
- DEPTH, 16, per-flow FIFO depth in pixels (power of 2, at least 2).
- DATA_W, 8, pixel width.
- SIZE_W, 7, width of the ext_size configuration word.
- TAG_W, $clog2(FLUX) with a minimum of 1, tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- in_din  in  FLUX*DATA_W  per-flow pixel data; flow f occupies bits [f*DATA_W +: DATA_W].
- in_write  in  FLUX  per-flow pixel write strobe.
- in_full  out  FLUX  per-flow FIFO full.
- cfg_size  in  FLUX*SIZE_W  per-flow ext_size (pixels per side).
- cfg_write  in  FLUX  per-flow configuration strobe.
- out_din  out  TAG_W+DATA_W  tagged pixel; {tag, pixel}.
- out_write  out  1  tagged pixel valid.
- out_full  in  FLUX  downstream per-flow full (the filter's in_pel full).
- blk_done  out  FLUX  one-cycle pulse when the last pixel of a block is issued.
- busy  out  FLUX  flow has a block loaded with pixels remaining.
- err  out  FLUX  sticky protocol error; only driven when the optional feature is compiled in.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFOs empty, all remaining counters 0, round-robin pointer 0.
  - out_write=0, out_din=0, blk_done=0, busy=0, err=0.
  - in_full=0 while reset is held.
- Reset asserted mid-block discards all buffered pixels and configuration; no partial output follows.
- FIFO:
  - in_full[f] is asserted exactly when count[f]==DEPTH.
  - A write while full is dropped and the count is unchanged.
  - Simultaneous push and pop on a full FIFO is still dropped: in_full is evaluated before the pop.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Configuration:
  - A cfg_write[f] pulse while the flow is inactive (remaining[f]==0) loads remaining[f] = cfg_size[f]*cfg_size[f], 2*SIZE_W bits, unsigned.
  - busy[f] rises the next cycle.
  - cfg_size==0 is ignored.
  - cfg_write while active is ignored.
- Eligibility: flow f is eligible when its FIFO is non-empty, remaining[f]!=0 and out_full[f]==0.
- Pixels arriving before configuration stay buffered and are not issued.
- Arbiter state machine, per cycle:
  - Grant the first eligible flow starting at ptr.
  - On a grant:
    - pop the FIFO;
    - remaining decrements by 1;
    - ptr becomes (granted+1) mod FLUX;
    - registered outputs next cycle are out_write=1 and out_din={f, data}.
  - With no eligible flow: out_write=0, out_din holds its last value, ptr is unchanged.
- Throughput and latency:
  - At most one pixel per cycle in total.
  - With all flows eligible, tags strictly alternate.
  - A pixel written at edge n is issued (out_write high) at edge n+2 at the earliest.
- Block completion:
  - When remaining goes 1→0, blk_done[f] pulses in the same cycle as that pixel's out_write, and busy[f] falls.
  - Excess pixels stay in the FIFO for the next block.
- out_full is sampled at grant time. The downstream FIFO's own margin absorbs the single pixel already in the output register.

Optional Feature:
- Macro ARB_ERR_CHECK_EN.
- When defined, err[f] is set and held until reset on any of:
  - in_write[f] while in_full[f];
  - cfg_write[f] while busy[f];
  - cfg_write[f] with cfg_size[f]==0.
- When undefined, err is tied to 0 and no check logic is synthesized.

Decomposition:
- Package flow_arb_pkg holds:
  - FLUX_MAX;
  - function tag_w(flux) implementing the $clog2 rule with a minimum of 1;
  - typedef blk_len_t as logic [2*SIZE_W-1:0];
  - a function rr_pick(eligible, ptr).
- One sub-module, flow_fifo (DATA_W, DEPTH, with push/pop/full/empty/count), instantiated once per flow.

Test Plan:
- Basic single flow: reset, cfg flow 0 with size=23, write 529 pixels 0..528 mod 256 back-to-back → 529 out_write beats with tag 0 in order; blk_done[0] on the 529th; busy[0] falls; first beat 2 cycles after the first write.
- Concurrent flows: both flows configured with size=23, both fed continuously → out tags alternate 0,1,0,1…; each flow gets exactly 529 beats; blk_done fires on both.
- Backpressure: hold out_full[1]=1 for 50 cycles mid-block → only tag 0 is issued during that window. Flow 1 FIFO fills and asserts in_full[1] after 16 writes; further writes are dropped; flow 1 resumes the cycle after release.
- Pre-config buffering: write 10 pixels to flow 1 before cfg → no output; cfg size=3 → exactly 9 beats issued; 1 pixel remains (count=1).
- Reset mid-block: assert rst low after 100 beats → outputs are 0 immediately; after release, a new cfg with size=4 gives 16 beats with no stale data.
- Error checks (ARB_ERR_CHECK_EN defined): cfg_write[0] while busy → err[0]=1 and remaining unchanged; without the macro, err stays 0.

Source files
------------

// File: rtl/flow_arb_pkg.sv
// Shared constants, types and helpers for the multi-flow input arbiter.
// rr_pick returns {found, index} of the first eligible flow at or after ptr.
package flow_arb_pkg;

  localparam int FLUX_MAX   = 16;
  localparam int PICK_W     = $clog2(FLUX_MAX);
  localparam int ARB_SIZE_W = 7;

  typedef logic [2*ARB_SIZE_W-1:0] blk_len_t;

  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 1;
  endfunction

  function automatic logic [PICK_W:0] rr_pick(
    input logic [FLUX_MAX-1:0] elig,
    input logic [PICK_W-1:0]   ptr,
    input int                  flux
  );
    logic [PICK_W:0] res;
    int              idx;
    res = '0;
    for (int i = 0; i < FLUX_MAX; i++) begin
      idx = (int'(ptr) + i) % flux;
      if ((i < flux) && !res[PICK_W] && elig[idx[PICK_W-1:0]]) begin
        res = {1'b1, idx[PICK_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/flow_fifo.sv
// Per-flow pixel FIFO. A pushed word becomes readable one cycle after the push,
// while occupancy (and therefore full) counts it immediately.
module flow_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_avail;
  logic              r_push_d;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_avail == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr];

  // storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // pointers, occupancy and readable-word count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_avail  <= '0;
      r_push_d <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_push_d <= w_push_ok;
      r_count  <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
      r_avail  <= r_avail + CW'(r_push_d) - CW'(w_pop_ok);
    end
  end

endmodule

// File: rtl/flow_input_arbiter.sv
// Buffers FLUX pixel streams and merges them round-robin into one tagged stream,
// gated per flow by a block length of size*size. Define ARB_ERR_CHECK_EN for sticky err.
module flow_input_arbiter
  import flow_arb_pkg::*;
#(
  parameter int FLUX   = 2,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 7,
  parameter int TAG_W  = tag_w(FLUX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FLUX*DATA_W-1:0]   in_din,
  input  logic [FLUX-1:0]          in_write,
  output logic [FLUX-1:0]          in_full,
  input  logic [FLUX*SIZE_W-1:0]   cfg_size,
  input  logic [FLUX-1:0]          cfg_write,
  output logic [TAG_W+DATA_W-1:0]  out_din,
  output logic                     out_write,
  input  logic [FLUX-1:0]          out_full,
  output logic [FLUX-1:0]          blk_done,
  output logic [FLUX-1:0]          busy,
  output logic [FLUX-1:0]          err
);

  localparam int RW = 2 * SIZE_W;

  logic [FLUX-1:0]           w_empty;
  logic [FLUX-1:0]           w_elig;
  logic [FLUX-1:0]           w_grant;
  logic [DATA_W-1:0]         w_fifo_dout [FLUX];
  logic [FLUX_MAX-1:0]       w_elig_ext;
  logic [PICK_W:0]           w_pick;
  logic                      w_gnt_vld;
  logic [PICK_W-1:0]         w_gnt_idx;
  logic [DATA_W-1:0]         w_gnt_data;
  logic [TAG_W-1:0]          w_ptr_nxt;
  logic [TAG_W-1:0]          r_ptr;
  logic                      r_out_write;
  logic [TAG_W+DATA_W-1:0]   r_out_din;

  for (genvar f = 0; f < FLUX; f++) begin : g_flow
    logic [SIZE_W-1:0] w_size;
    logic [RW-1:0]     w_sq;
    logic [RW-1:0]     w_rem_nxt;
    logic [RW-1:0]     r_rem;
    logic              w_load;
    logic              r_busy;
    logic              r_done;

    assign w_size = cfg_size[f*SIZE_W +: SIZE_W];
    assign w_sq   = RW'(w_size) * RW'(w_size);
    assign w_load = cfg_write[f] && (r_rem == '0) && (w_size != '0);

    flow_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (in_write[f]),
      .i_pop   (w_grant[f]),
      .i_din   (in_din[f*DATA_W +: DATA_W]),
      .o_dout  (w_fifo_dout[f]),
      .o_full  (in_full[f]),
      .o_empty (w_empty[f])
    );

    assign w_elig[f] = !w_empty[f] && (r_rem != '0) && !out_full[f];

    // remaining-pixel count: load only when idle, otherwise count down on grants
    always_comb begin
      w_rem_nxt = r_rem;
      if (w_load) begin
        w_rem_nxt = w_sq;
      end else if (w_grant[f]) begin
        w_rem_nxt = r_rem - RW'(1);
      end else begin
        w_rem_nxt = r_rem;
      end
    end

    // per-flow block state and its registered status outputs
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_rem  <= '0;
        r_busy <= 1'b0;
        r_done <= 1'b0;
      end else begin
        r_rem  <= w_rem_nxt;
        r_busy <= (w_rem_nxt != '0);
        r_done <= w_grant[f] && (r_rem == RW'(1));
      end
    end

    assign busy[f]     = r_busy;
    assign blk_done[f] = r_done;

`ifdef ARB_ERR_CHECK_EN
    logic r_err;

    // sticky protocol error: overflow write, reconfig while busy, or zero size
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_err <= 1'b0;
      end else if ((in_write[f] && in_full[f]) ||
                   (cfg_write[f] && r_busy) ||
                   (cfg_write[f] && (w_size == '0))) begin
        r_err <= 1'b1;
      end
    end

    assign err[f] = r_err;
`else
    assign err[f] = 1'b0;
`endif
  end

  // round-robin grant and pixel select
  always_comb begin
    w_elig_ext             = '0;
    w_elig_ext[FLUX-1:0]   = w_elig;
    w_pick                 = rr_pick(w_elig_ext, PICK_W'(r_ptr), FLUX);
    w_gnt_vld              = w_pick[PICK_W];
    w_gnt_idx              = w_pick[PICK_W-1:0];
    w_grant                = '0;
    w_gnt_data             = '0;
    for (int i = 0; i < FLUX; i++) begin
      if (w_gnt_vld && (w_gnt_idx == PICK_W'(i))) begin
        w_grant[i] = 1'b1;
        w_gnt_data = w_fifo_dout[i];
      end else begin
        w_grant[i] = 1'b0;
      end
    end
    if (w_gnt_idx == PICK_W'(FLUX - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = TAG_W'(w_gnt_idx + PICK_W'(1));
    end
  end

  // output register; out_din holds its last value on idle cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_out_write <= 1'b0;
      r_out_din   <= '0;
    end else begin
      r_out_write <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_out_din <= {TAG_W'(w_gnt_idx), w_gnt_data};
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  assign out_write = r_out_write;
  assign out_din   = r_out_din;

endmodule

// File: tb/tb_flow_input_arbiter.sv
// Self-checking bench for flow_input_arbiter: a vector table, directed block
// sequences and random traffic, all checked against a queue-based model.
`timescale 1ns/1ps
module tb_flow_input_arbiter;

`ifdef ARB_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_din = '0;
  logic [1:0]  in_write = '0;
  logic [1:0]  in_full;
  logic [13:0] cfg_size = '0;
  logic [1:0]  cfg_write = '0;
  logic [8:0]  out_din;
  logic        out_write;
  logic [1:0]  out_full = '0;
  logic [1:0]  blk_done;
  logic [1:0]  busy;
  logic [1:0]  err;

  flow_input_arbiter #(.FLUX(2), .DEPTH(DEPTH), .DATA_W(8), .SIZE_W(7)) dut (
    .clk(clk), .rst(rst), .in_din(in_din), .in_write(in_write), .in_full(in_full),
    .cfg_size(cfg_size), .cfg_write(cfg_write), .out_din(out_din), .out_write(out_write),
    .out_full(out_full), .blk_done(blk_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // reference model state: pixel queues with push edge stamps, remaining counts
  logic [7:0] mq [2][$];
  int         mts[2][$];
  int         mrem[2];
  int         mptr, eno;
  logic       exp_ow;
  logic [8:0] exp_od;
  logic [1:0] exp_done, exp_busy, exp_full, exp_err;

  int beats[2], dones[2];
  int cyc = 0, first_ow, alt_viol;
  logic prev_ow, prev_tag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < 2; f++) begin
      mq[f].delete(); mts[f].delete(); mrem[f] = 0;
    end
    mptr = 0; eno = 0;
    exp_ow = 0; exp_od = '0; exp_done = '0; exp_busy = '0; exp_full = '0; exp_err = '0;
  endtask

  task automatic model_edge(input logic [1:0] wr, input logic [15:0] din,
                            input logic [1:0] cw, input logic [13:0] sz, input logic [1:0] of);
    int g;
    logic [1:0] fullpre, busypre;
    logic [6:0] s;
    eno++;
    for (int f = 0; f < 2; f++) begin
      fullpre[f] = (mq[f].size() == DEPTH);
      busypre[f] = (mrem[f] != 0);
    end
    g = -1;
    for (int k = 0; k < 2; k++) begin
      int f;
      f = (mptr + k) % 2;
      if (g < 0 && mq[f].size() > 0 && mrem[f] > 0 && !of[f]) begin
        if (mts[f][0] <= eno - 2) g = f;
      end
    end
    exp_done = '0;
    if (g >= 0) begin
      exp_ow = 1'b1;
      exp_od = {1'(g), mq[g][0]};
      void'(mq[g].pop_front());
      void'(mts[g].pop_front());
      mrem[g]--;
      if (mrem[g] == 0) exp_done[g] = 1'b1;
      mptr = (g + 1) % 2;
    end else begin
      exp_ow = 1'b0;
    end
    for (int f = 0; f < 2; f++) begin
      s = sz[f*7 +: 7];
      if (ERR_EN && ((wr[f] && fullpre[f]) || (cw[f] && busypre[f]) || (cw[f] && s == 0)))
        exp_err[f] = 1'b1;
      if (wr[f] && !fullpre[f]) begin
        mq[f].push_back(din[f*8 +: 8]);
        mts[f].push_back(eno);
      end
      if (cw[f] && !busypre[f] && s != 0) mrem[f] = int'(s) * int'(s);
      exp_busy[f] = (mrem[f] != 0);
      exp_full[f] = (mq[f].size() == DEPTH);
    end
  endtask

  task automatic step(input logic [1:0] wr, input logic [15:0] din,
                      input logic [1:0] cw, input logic [13:0] sz, input logic [1:0] of);
    in_write = wr; in_din = din; cfg_write = cw; cfg_size = sz; out_full = of;
    @(posedge clk);
    model_edge(wr, din, cw, sz, of);
    @(negedge clk);
    cyc++;
    chk("out_write", out_write, exp_ow);
    chk("out_din", out_din, exp_od);
    chk("blk_done", blk_done, exp_done);
    chk("busy", busy, exp_busy);
    chk("in_full", in_full, exp_full);
    chk("err", err, exp_err);
    if (out_write === 1'b1) begin
      if (first_ow < 0) first_ow = cyc;
      if (prev_ow && (prev_tag == out_din[8])) alt_viol++;
      beats[out_din[8]]++;
    end
    prev_ow = out_write; prev_tag = out_din[8];
    dones[0] += int'(blk_done[0]);
    dones[1] += int'(blk_done[1]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_write = '0; in_din = '0; cfg_write = '0; cfg_size = '0; out_full = '0;
    rst = 1'b0;
    #1;
    chk("rst_out_write", out_write, 1'b0);
    chk("rst_out_din", out_din, 9'h000);
    chk("rst_busy", busy, 2'b00);
    chk("rst_blk_done", blk_done, 2'b00);
    chk("rst_in_full", in_full, 2'b00);
    chk("rst_err", err, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    beats = '{0, 0}; dones = '{0, 0};
    first_ow = -1; prev_ow = 1'b0; prev_tag = 1'b0; alt_viol = 0;
  endtask

  typedef struct {
    logic [1:0]  wr;  logic [15:0] din; logic [1:0] cw; logic [13:0] sz; logic [1:0] of;
    logic        ow;  logic [8:0]  od;  logic [1:0] done; logic [1:0] bsy; logic [1:0] er;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int w_cyc, t1;
    tbl[0] = '{2'b00, 16'h0000, 2'b01, 14'h0001, 2'b00, 1'b0, 9'h000, 2'b00, 2'b01, 2'b00};
    tbl[1] = '{2'b01, 16'h00A5, 2'b00, 14'h0000, 2'b00, 1'b0, 9'h000, 2'b00, 2'b01, 2'b00};
    tbl[2] = '{2'b00, 16'h0000, 2'b00, 14'h0000, 2'b00, 1'b0, 9'h000, 2'b00, 2'b01, 2'b00};
    tbl[3] = '{2'b00, 16'h0000, 2'b00, 14'h0000, 2'b00, 1'b1, 9'h0A5, 2'b01, 2'b00, 2'b00};
    tbl[4] = '{2'b00, 16'h0000, 2'b00, 14'h0000, 2'b00, 1'b0, 9'h0A5, 2'b00, 2'b00, 2'b00};
    tbl[5] = '{2'b10, 16'h3C00, 2'b00, 14'h0000, 2'b00, 1'b0, 9'h0A5, 2'b00, 2'b00, 2'b00};
    tbl[6] = '{2'b00, 16'h0000, 2'b10, 14'h0080, 2'b00, 1'b0, 9'h0A5, 2'b00, 2'b10, 2'b00};
    tbl[7] = '{2'b00, 16'h0000, 2'b00, 14'h0000, 2'b10, 1'b0, 9'h0A5, 2'b00, 2'b10, 2'b00};
    tbl[8] = '{2'b00, 16'h0000, 2'b00, 14'h0000, 2'b00, 1'b1, 9'h13C, 2'b10, 2'b00, 2'b00};
    tbl[9] = '{2'b00, 16'h0000, 2'b01, 14'h0000, 2'b00, 1'b0, 9'h13C, 2'b00, 2'b00, {1'b0, ERR_EN}};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_write = tbl[i].wr; in_din = tbl[i].din; cfg_write = tbl[i].cw;
      cfg_size = tbl[i].sz; out_full = tbl[i].of;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_out_write", i), out_write, tbl[i].ow);
      chk($sformatf("tbl%0d_out_din", i), out_din, tbl[i].od);
      chk($sformatf("tbl%0d_blk_done", i), blk_done, tbl[i].done);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_in_full", i), in_full, 2'b00);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
    end

    // single flow, one 23x23 block
    do_reset();
    step(2'b00, 16'h0, 2'b01, 14'd23, 2'b00);
    w_cyc = cyc + 1;
    for (int i = 0; i < 529; i++) step(2'b01, {8'h00, 8'(i)}, 2'b00, 14'd0, 2'b00);
    for (int i = 0; i < 40 && busy[0]; i++) step(2'b00, 16'h0, 2'b00, 14'd0, 2'b00);
    chk("t1_latency", first_ow - w_cyc, 2);
    chk("t1_beats0", beats[0], 529);
    chk("t1_beats1", beats[1], 0);
    chk("t1_done", dones[0], 1);
    chk("t1_busy_fall", busy, 2'b00);

    // two flows fed continuously: strict alternation
    do_reset();
    step(2'b00, 16'h0, 2'b11, {7'd23, 7'd23}, 2'b00);
    for (int i = 0; i < 3000 && !(dones[0] > 0 && dones[1] > 0); i++)
      step(2'b11, 16'($urandom), 2'b00, 14'd0, 2'b00);
    chk("t2_beats0", beats[0], 529);
    chk("t2_beats1", beats[1], 529);
    chk("t2_done0", dones[0], 1);
    chk("t2_done1", dones[1], 1);
    chk("t2_alternate", alt_viol, 0);

    // backpressure on flow 1 mid-block
    do_reset();
    step(2'b00, 16'h0, 2'b11, {7'd23, 7'd23}, 2'b00);
    for (int i = 0; i < 40; i++) step(2'b11, 16'($urandom), 2'b00, 14'd0, 2'b00);
    t1 = beats[1];
    for (int i = 0; i < 50; i++) step(2'b11, 16'($urandom), 2'b00, 14'd0, 2'b10);
    chk("t3_no_tag1", beats[1] - t1, 0);
    chk("t3_in_full1", in_full[1], 1'b1);
    step(2'b11, 16'($urandom), 2'b00, 14'd0, 2'b00);
    chk("t3_resume_write", out_write, 1'b1);
    chk("t3_resume_tag", out_din[8], 1'b1);
    for (int i = 0; i < 3000 && !(dones[0] > 0 && dones[1] > 0); i++)
      step(2'b11, 16'($urandom), 2'b00, 14'd0, 2'b00);
    chk("t3_done0", dones[0], 1);
    chk("t3_done1", dones[1], 1);

    // pixels buffered before configuration
    do_reset();
    for (int i = 0; i < 10; i++) step(2'b10, {8'(8'h40 + i), 8'h00}, 2'b00, 14'd0, 2'b00);
    for (int i = 0; i < 5; i++) step(2'b00, 16'h0, 2'b00, 14'd0, 2'b00);
    chk("t4_no_early", beats[1], 0);
    step(2'b00, 16'h0, 2'b10, {7'd3, 7'd0}, 2'b00);
    for (int i = 0; i < 20; i++) step(2'b00, 16'h0, 2'b00, 14'd0, 2'b00);
    chk("t4_beats9", beats[1], 9);
    step(2'b00, 16'h0, 2'b10, {7'd1, 7'd0}, 2'b00);
    for (int i = 0; i < 5; i++) step(2'b00, 16'h0, 2'b00, 14'd0, 2'b00);
    chk("t4_leftover", beats[1], 10);
    chk("t4_leftover_data", out_din, 9'h149);

    // reset in the middle of a block
    do_reset();
    step(2'b00, 16'h0, 2'b01, 14'd23, 2'b00);
    for (int i = 0; i < 400 && beats[0] < 100; i++) step(2'b01, 16'($urandom), 2'b00, 14'd0, 2'b00);
    rst = 1'b0;
    #1;
    chk("t5_rst_out_write", out_write, 1'b0);
    chk("t5_rst_out_din", out_din, 9'h000);
    chk("t5_rst_busy", busy, 2'b00);
    chk("t5_rst_in_full", in_full, 2'b00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    beats = '{0, 0}; dones = '{0, 0};
    step(2'b00, 16'h0, 2'b01, 14'd4, 2'b00);
    for (int i = 0; i < 16; i++)
      step(2'b01, {8'h00, 8'(8'hB0 + i)}, (i == 4) ? 2'b01 : 2'b00, (i == 4) ? 14'd9 : 14'd0, 2'b00);
    for (int i = 0; i < 20; i++) step(2'b00, 16'h0, 2'b00, 14'd0, 2'b00);
    chk("t5_beats", beats[0], 16);
    chk("t5_done", dones[0], 1);
    chk("t5_err_cfg_busy", err[0], ERR_EN);

    // random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [1:0] cw;
      cw = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(2'($urandom_range(0, 3)), 16'($urandom), cw,
           {7'($urandom_range(0, 5)), 7'($urandom_range(0, 5))},
           2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
